// File: rtl/rename_serialize_controller_pkg.sv
// Shared rename-stage types for the serialize controller: per-lane serialize kinds,
// controller phases, and the condition that lets a serialized op issue.
package rename_serialize_controller_pkg;

    typedef enum logic [1:0] {
        SER_NONE    = 2'd0,
        SER_PLAIN   = 2'd1,
        SER_FENCE   = 2'd2,
        SER_FENCE_I = 2'd3
    } SerializeKind;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        ISSUE    = 2'd2,
        WAIT_OWN = 2'd3
    } SerializePhase;

    function automatic int idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Plain ops only need older work retired; fences also need the store queue drained.
    function automatic logic ser_cond(input SerializeKind kind,
                                      input logic al_empty,
                                      input logic sq_empty);
        return (kind == SER_PLAIN) ? al_empty : (al_empty && sq_empty);
    endfunction

endpackage

// File: rtl/rename_serialize_controller_if.sv
// Pipeline-register / rename-logic side of the serialize controller, grouped as one bundle.
interface rename_serialize_controller_if #(
    parameter int WIDTH          = 2,
    parameter int WAIT_CNT_WIDTH = 16
);
    logic                      stall;
    logic                      clear;
    logic                      activeListEmpty;
    logic                      storeQueueEmpty;
    logic [WIDTH-1:0]          valid;
    logic [2*WIDTH-1:0]        serKind;
    logic                      icFlushAck;
    logic [WIDTH-1:0]          laneEnable;
    logic                      serialize;
    logic                      icFlushReq;
    logic [WAIT_CNT_WIDTH-1:0] waitCycles;
    logic                      hung;

    modport master (
        output stall, clear, activeListEmpty, storeQueueEmpty, valid, serKind, icFlushAck,
        input  laneEnable, serialize, icFlushReq, waitCycles, hung
    );

    modport slave (
        input  stall, clear, activeListEmpty, storeQueueEmpty, valid, serKind, icFlushAck,
        output laneEnable, serialize, icFlushReq, waitCycles, hung
    );
endinterface

// File: rtl/rename_serialize_controller_lane_picker.sv
// Finds the oldest pending lane carrying a serialized op and the pending lanes older than it.
module serialize_lane_picker
    import rename_serialize_controller_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0]   pending,
    input  logic [2*WIDTH-1:0] ser_kind,
    output logic [WIDTH-1:0]   k_onehot,
    output logic [IDX_W-1:0]   k_index,
    output logic               k_found,
    output logic [WIDTH-1:0]   older_mask
);

    // Scan from lane 0 upward; with no serialized lane, older_mask is simply pending.
    always_comb begin
        k_onehot   = '0;
        k_index    = '0;
        k_found    = 1'b0;
        older_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!k_found) begin
                if (pending[i] && (ser_kind[2*i +: 2] != SER_NONE)) begin
                    k_found     = 1'b1;
                    k_onehot[i] = 1'b1;
                    k_index     = IDX_W'(i);
                end else begin
                    older_mask[i] = pending[i];
                end
            end
        end
    end

endmodule

// File: rtl/rename_serialize_controller.sv
// Rename-stage serializer: splits a group into older lanes, the serialized op alone,
// then younger lanes, with optional I-cache flush and a saturating wait counter.
module rename_serialize_controller
    import rename_serialize_controller_pkg::*;
#(
    parameter int WIDTH          = 2,
    parameter int WAIT_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    rename_serialize_controller_if.slave bus
);

    localparam int IDX_W = idx_width(WIDTH);

    SerializePhase             state_q, state_d;
    logic [WIDTH-1:0]          done_mask_q, done_mask_d;
    logic [WAIT_CNT_WIDTH-1:0] wait_q, wait_d, wait_inc;

    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] k_onehot;
    logic [IDX_W-1:0] k_index;
    logic             k_found;
    logic [WIDTH-1:0] older_mask;
    SerializeKind     k_kind;
    logic             k_cond;
    logic             has_older;

    assign pending = bus.valid & ~done_mask_q;

    serialize_lane_picker #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_picker (
        .pending    (pending),
        .ser_kind   (bus.serKind),
        .k_onehot   (k_onehot),
        .k_index    (k_index),
        .k_found    (k_found),
        .older_mask (older_mask)
    );

    assign k_kind    = SerializeKind'(bus.serKind[2*int'(k_index) +: 2]);
    assign k_cond    = ser_cond(k_kind, bus.activeListEmpty, bus.storeQueueEmpty);
    assign has_older = |older_mask;
    assign wait_inc  = (&wait_q) ? wait_q : (wait_q + WAIT_CNT_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            done_mask_q <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            done_mask_q <= done_mask_d;
            wait_q      <= wait_d;
        end
    end

    // Clear overrides stall and any ack arriving in the same cycle.
    always_comb begin
        state_d     = state_q;
        done_mask_d = done_mask_q;
        wait_d      = wait_q;
        if (bus.clear) begin
            state_d     = IDLE;
            done_mask_d = '0;
            wait_d      = '0;
        end else if (!bus.stall) begin
            unique case (state_q)
                IDLE: begin
                    if (!k_found) begin
                        done_mask_d = '0;
                    end else if (has_older) begin
                        done_mask_d = done_mask_q | older_mask;
                    end else if (!k_cond) begin
                        wait_d = wait_inc;
                    end else if (k_kind == SER_FENCE_I) begin
                        state_d = FLUSH;
                    end else begin
                        done_mask_d = done_mask_q | k_onehot;
                        state_d     = WAIT_OWN;
                    end
                end
                FLUSH: begin
                    wait_d = wait_inc;
                    if (bus.icFlushAck) begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    done_mask_d = done_mask_q | k_onehot;
                    state_d     = WAIT_OWN;
                end
                WAIT_OWN: begin
                    if (bus.activeListEmpty && bus.storeQueueEmpty) begin
                        state_d = IDLE;
                        wait_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs read zero while reset is held so downstream sees a quiet stage immediately.
    always_comb begin
        bus.laneEnable = '0;
        bus.serialize  = 1'b0;
        bus.icFlushReq = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!k_found) begin
                    bus.laneEnable = pending;
                end else begin
                    bus.serialize = 1'b1;
                    if (has_older) begin
                        bus.laneEnable = older_mask;
                    end else if (k_cond && (k_kind != SER_FENCE_I)) begin
                        bus.laneEnable = k_onehot;
                    end
                end
            end
            FLUSH: begin
                bus.serialize  = 1'b1;
                bus.icFlushReq = 1'b1;
            end
            ISSUE: begin
                bus.serialize  = 1'b1;
                bus.laneEnable = k_onehot;
            end
            WAIT_OWN: bus.serialize = 1'b1;
            default: bus.serialize = 1'b1;
        endcase
        if (bus.stall || bus.clear || rst) begin
            bus.laneEnable = '0;
        end
        if (rst) begin
            bus.serialize  = 1'b0;
            bus.icFlushReq = 1'b0;
        end
    end

    assign bus.waitCycles = wait_q;
    assign bus.hung       = &wait_q;

endmodule
